cpu_state_dumper: RTL and testbench

//  Hardware counterpart of the bench-side per-cycle state printout. On request it walks the

---
 rtl/cpu_state_dumper_if.sv | 29 ++
 rtl/cpu_state_dumper.sv | 190 +++++++++++++++++++
 tb/tb_cpu_state_dumper.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_state_dumper_if.sv
// Trace-beat stream between the state dumper and its sink.
//   valid : beat on data/tag/last is meaningful (driven by master)
//   ready : sink accepts the beat this cycle (driven by slave)
//   data  : 32-bit beat payload
//   tag   : 0x00 cycle count, 0x01 PC, 0x40+i register i, 0x80+j memory word j
//   last  : final beat of a dump
interface cpu_state_dumper_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [7:0]  tag;
  logic        last;

  modport master (
    output valid,
    output data,
    output tag,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  tag,
    input  last,
    output ready
  );
endinterface

// File: rtl/cpu_state_dumper.sv
// Hardware CPU state dumper. On a request it emits a header (cycle count, PC snapshot), then
// every register-file entry, then the low data-memory words, as tagged 32-bit beats on a
// valid/ready stream.
// Ports:
//   clk_i, rst_n_i  clock (rising edge) and asynchronous active-low reset
//   start_i         CPU running; enables the free-running cycle counter
//   dump_req_i      one-cycle dump request
//   pc_i            current PC, snapshotted when a dump is accepted
//   reg_addr_o      register-file read address (0 outside the register phase)
//   reg_data_i      combinational register read data
//   mem_addr_o      word-aligned data-memory byte address (0 outside the memory phase)
//   mem_data_i      combinational little-endian memory word
//   out_io          beat stream (master side)
//   busy_o          dump in progress or beat still outstanding
//   overrun_o       sticky: a request was dropped because one was already pending
module cpu_state_dumper #(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned NUM_MEM_WORDS = 8,
  parameter int unsigned MEM_AW        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  dump_req_i,
  input  logic [31:0]           pc_i,
  output logic [5:0]            reg_addr_o,
  input  logic [31:0]           reg_data_i,
  output logic [MEM_AW-1:0]     mem_addr_o,
  input  logic [31:0]           mem_data_i,
  cpu_state_dumper_if.master    out_io,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam logic [5:0] LastReg = 6'(NUM_REGS - 1);
  localparam logic [5:0] LastMem = 6'(NUM_MEM_WORDS - 1);

  // State names the source of the NEXT beat to load. The cycle-count header beat is loaded
  // directly on leaving StIdle so it appears the cycle after the request.
  typedef enum logic [1:0] {
    StIdle,
    StHdrPc,
    StRegs,
    StMem
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] pc_snap_q, pc_snap_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [7:0]  out_tag_q, out_tag_d;
  logic        out_last_q, out_last_d;

  logic load;
  logic req_any;
  logic accept;

  // A new beat may be loaded when the output slot is empty or being consumed this cycle.
  assign load    = !out_valid_q || out_io.ready;
  assign req_any = dump_req_i || pending_q;
  assign accept  = (state_q == StIdle) && load && req_any;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cycle_cnt_d = start_i ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    pc_snap_d   = pc_snap_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_last_d  = out_last_q;

    // One-deep request queue. When a pending request is consumed, a coincident new request
    // takes its place; otherwise a request that cannot start now is parked or dropped.
    if (accept) begin
      pending_d = pending_q && dump_req_i;
    end else if (dump_req_i) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    if (load) begin
      case (state_q)
        StIdle: begin
          if (req_any) begin
            out_valid_d = 1'b1;
            out_data_d  = cycle_cnt_q;
            out_tag_d   = 8'h00;
            out_last_d  = 1'b0;
            pc_snap_d   = pc_i;
            state_d     = StHdrPc;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
        StHdrPc: begin
          out_valid_d = 1'b1;
          out_data_d  = pc_snap_q;
          out_tag_d   = 8'h01;
          out_last_d  = 1'b0;
          idx_d       = 6'd0;
          state_d     = StRegs;
        end
        StRegs: begin
          out_valid_d = 1'b1;
          out_data_d  = reg_data_i;
          out_tag_d   = 8'h40 | {2'b00, idx_q};
          out_last_d  = 1'b0;
          if (idx_q == LastReg) begin
            idx_d   = 6'd0;
            state_d = StMem;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        StMem: begin
          out_valid_d = 1'b1;
          out_data_d  = mem_data_i;
          out_tag_d   = 8'h80 | {2'b00, idx_q};
          out_last_d  = (idx_q == LastMem);
          if (idx_q == LastMem) begin
            idx_d   = 6'd0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      idx_q       <= 6'd0;
      cycle_cnt_q <= 32'd0;
      pc_snap_q   <= 32'd0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_tag_q   <= 8'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cycle_cnt_q <= cycle_cnt_d;
      pc_snap_q   <= pc_snap_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_last_q  <= out_last_d;
    end
  end

  // Read addresses point at the entry to be captured on the next load edge.
  always_comb begin
    reg_addr_o = 6'd0;
    mem_addr_o = '0;
    if (state_q == StRegs) begin
      reg_addr_o = idx_q;
    end
    if (state_q == StMem) begin
      mem_addr_o = MEM_AW'({idx_q, 2'b00});
    end
  end

  assign out_io.valid = out_valid_q;
  assign out_io.data  = out_data_q;
  assign out_io.tag   = out_tag_q;
  assign out_io.last  = out_last_q;
  assign busy_o       = (state_q != StIdle) || out_valid_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Directed bench for cpu_state_dumper: default instance plus a 4-register / 1-word instance.
module tb_cpu_state_dumper;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] data;
    logic        last;
    int          stamp;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        req1, req2;
  logic [31:0] pc;
  logic [5:0]  reg_addr1, reg_addr2;
  logic [31:0] reg_data1, reg_data2;
  logic [7:0]  mem_addr1, mem_addr2;
  logic [31:0] mem_data1, mem_data2;
  logic        busy1, busy2, ovr1, ovr2;

  logic [31:0] regs [64];
  logic [7:0]  memb [256];

  beat_t q1[$];
  beat_t q2[$];

  int bcyc = 0;
  int req_cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  // Live presented-beat check (used while ready toggles)
  logic        hold_chk = 1'b0;
  int          cur_base = 0;
  logic [31:0] cur_cyc = 0;
  logic [31:0] cur_pc = 0;

  cpu_state_dumper_if bus1 ();
  cpu_state_dumper_if bus2 ();

  cpu_state_dumper dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .dump_req_i (req1),
    .pc_i       (pc),
    .reg_addr_o (reg_addr1),
    .reg_data_i (reg_data1),
    .mem_addr_o (mem_addr1),
    .mem_data_i (mem_data1),
    .out_io     (bus1),
    .busy_o     (busy1),
    .overrun_o  (ovr1)
  );

  cpu_state_dumper #(
    .NUM_REGS      (4),
    .NUM_MEM_WORDS (1),
    .MEM_AW        (8)
  ) dut2 (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .dump_req_i (req2),
    .pc_i       (pc),
    .reg_addr_o (reg_addr2),
    .reg_data_i (reg_data2),
    .mem_addr_o (mem_addr2),
    .mem_data_i (mem_data2),
    .out_io     (bus2),
    .busy_o     (busy2),
    .overrun_o  (ovr2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bcyc <= bcyc + 1;

  // Register file and byte-wide data memory models
  assign reg_data1 = regs[reg_addr1];
  assign reg_data2 = regs[reg_addr2];
  assign mem_data1 = {memb[8'(mem_addr1 + 8'd3)], memb[8'(mem_addr1 + 8'd2)],
                      memb[8'(mem_addr1 + 8'd1)], memb[mem_addr1]};
  assign mem_data2 = {memb[8'(mem_addr2 + 8'd3)], memb[8'(mem_addr2 + 8'd2)],
                      memb[8'(mem_addr2 + 8'd1)], memb[mem_addr2]};

  function automatic logic [31:0] regw(input int i);
    return (i == 8) ? 32'd5 : 32'h1234_0000 + 32'(i) * 32'h11;
  endfunction

  function automatic logic [31:0] memw(input int j);
    return (j == 0) ? 32'd5 : 32'hA500_0000 | (32'(j) * 32'h0101);
  endfunction

  function automatic logic [7:0] exp_tag(input int k, input int nr);
    if (k == 0) return 8'h00;
    if (k == 1) return 8'h01;
    if (k < nr + 2) return 8'(8'h40 + k - 2);
    return 8'(8'h80 + k - 2 - nr);
  endfunction

  function automatic logic [31:0] exp_data(input int k, input int nr, input logic [31:0] cyc,
                                           input logic [31:0] p);
    if (k == 0) return cyc;
    if (k == 1) return p;
    if (k < nr + 2) return regw(k - 2);
    return memw(k - 2 - nr);
  endfunction

  function automatic int qsize(input int which);
    return (which == 1) ? q1.size() : q2.size();
  endfunction

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (hold_chk && bus1.valid && (q1.size() - cur_base) < 42) begin
      check_eq("presented_tag", {24'h0, bus1.tag}, {24'h0, exp_tag(q1.size() - cur_base, 32)});
      check_eq("presented_data", bus1.data,
               exp_data(q1.size() - cur_base, 32, cur_cyc, cur_pc));
    end
    if (bus1.valid && bus1.ready) begin
      b.tag = bus1.tag; b.data = bus1.data; b.last = bus1.last; b.stamp = bcyc;
      q1.push_back(b);
    end
    if (bus2.valid && bus2.ready) begin
      b.tag = bus2.tag; b.data = bus2.data; b.last = bus2.last; b.stamp = bcyc;
      q2.push_back(b);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(input int which);
    if (which == 1) req1 = 1'b1; else req2 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    req2 = 1'b0;
    req_cyc = bcyc;
  endtask

  task automatic wait_beats(input int which, input int n, input int budget);
    int t = 0;
    while (qsize(which) < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (qsize(which) < n) check_eq("beat_timeout", 32'(qsize(which)), 32'(n));
  endtask

  task automatic check_dump(input int which, input int base, input int nr, input int nm,
                            input logic [31:0] cyc, input logic [31:0] p, input string pfx);
    beat_t b;
    int    n = nr + nm + 2;
    for (int k = 0; k < n; k++) begin
      if (base + k >= qsize(which)) begin
        check_eq({pfx, "_short"}, 32'(qsize(which)), 32'(base + n));
        break;
      end
      b = (which == 1) ? q1[base + k] : q2[base + k];
      check_eq($sformatf("%s_b%0d_tag", pfx, k), {24'h0, b.tag}, {24'h0, exp_tag(k, nr)});
      check_eq($sformatf("%s_b%0d_data", pfx, k), b.data, exp_data(k, nr, cyc, p));
      check_eq($sformatf("%s_b%0d_last", pfx, k), {31'h0, b.last}, {31'h0, k == n - 1});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = regw(i);
    for (int i = 0; i < 256; i++) memb[i] = 8'h0;
    for (int j = 0; j < 64; j++) begin
      logic [31:0] w;
      w = memw(j);
      memb[4*j]     = w[7:0];
      memb[4*j + 1] = w[15:8];
      memb[4*j + 2] = w[23:16];
      memb[4*j + 3] = w[31:24];
    end

    rst_n = 1'b0; start = 1'b0; req1 = 1'b0; req2 = 1'b0; pc = 32'h0;
    bus1.ready = 1'b0; bus2.ready = 1'b0;
    #2;
    check_eq("rst_valid", {31'h0, bus1.valid}, 32'h0);
    check_eq("rst_busy", {31'h0, busy1}, 32'h0);
    check_eq("rst_overrun", {31'h0, ovr1}, 32'h0);
    check_eq("rst_last", {31'h0, bus1.last}, 32'h0);
    check_eq("rst_data", bus1.data, 32'h0);
    check_eq("rst_tag", {24'h0, bus1.tag}, 32'h0);
    check_eq("rst_reg_addr", {26'h0, reg_addr1}, 32'h0);
    check_eq("rst_mem_addr", {24'h0, mem_addr1}, 32'h0);
    #10 rst_n = 1'b1;
    step(1);

    // 1: ten running cycles, then a dump at full throughput
    bus1.ready = 1'b1; bus2.ready = 1'b1;
    start = 1'b1;
    step(10);
    start = 1'b0;
    pc = 32'h0000_1040;
    pulse_req(1);
    wait_beats(1, 42, 200);
    check_dump(1, 0, 32, 8, 32'd10, 32'h0000_1040, "t1");
    if (q1.size() >= 42) begin
      check_eq("t1_first_latency", 32'(q1[0].stamp), 32'(req_cyc));
      check_eq("t1_span", 32'(q1[41].stamp - q1[0].stamp), 32'd41);
      check_eq("t1_r8", q1[10].data, 32'd5);
      check_eq("t1_mem0", q1[34].data, 32'd5);
    end
    step(3);
    check_eq("t1_idle_busy", {31'h0, busy1}, 32'h0);

    // 2: ready toggles mid-REGS; presented beat checked every cycle
    q1.delete();
    cur_base = 0; cur_cyc = 32'd10; cur_pc = 32'h0000_2000;
    pc = 32'h0000_2000;
    hold_chk = 1'b1;
    pulse_req(1);
    wait_beats(1, 12, 100);
    for (int i = 0; i < 20; i++) begin
      bus1.ready = ~bus1.ready;
      step(1);
    end
    bus1.ready = 1'b1;
    wait_beats(1, 42, 200);
    hold_chk = 1'b0;
    check_dump(1, 0, 32, 8, 32'd10, 32'h0000_2000, "t2");
    step(3);

    // 3: one pending request runs back-to-back; a third is dropped
    q1.delete();
    pc = 32'h0000_3000;
    pulse_req(1);
    pc = 32'h0000_3100;
    wait_beats(1, 5, 50);
    pulse_req(1);
    step(1);
    check_eq("t3_ovr_after_pend", {31'h0, ovr1}, 32'h0);
    wait_beats(1, 15, 50);
    pulse_req(1);
    step(1);
    check_eq("t3_ovr_after_drop", {31'h0, ovr1}, 32'h1);
    wait_beats(1, 84, 300);
    check_dump(1, 0, 32, 8, 32'd10, 32'h0000_3000, "t3a");
    check_dump(1, 42, 32, 8, 32'd10, 32'h0000_3100, "t3b");
    if (q1.size() >= 43)
      check_eq("t3_back_to_back", 32'(q1[42].stamp - q1[41].stamp), 32'd1);
    step(20);
    check_eq("t3_two_dumps", 32'(q1.size()), 32'd84);
    check_eq("t3_busy_end", {31'h0, busy1}, 32'h0);

    // 4: asynchronous reset mid-dump, then a fresh full dump
    q1.delete();
    pc = 32'h0000_4000;
    pulse_req(1);
    wait_beats(1, 20, 100);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t4_valid", {31'h0, bus1.valid}, 32'h0);
    check_eq("t4_busy", {31'h0, busy1}, 32'h0);
    check_eq("t4_overrun", {31'h0, ovr1}, 32'h0);
    #13 rst_n = 1'b1;
    step(2);
    q1.delete();
    pulse_req(1);
    wait_beats(1, 42, 200);
    check_dump(1, 0, 32, 8, 32'd0, 32'h0000_4000, "t4");
    step(10);
    check_eq("t4_no_extra", 32'(q1.size()), 32'd42);

    // 5: cycle counter wraps to zero
    q1.delete();
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    #2 release dut.cycle_cnt_q;
    start = 1'b1;
    step(1);
    start = 1'b0;
    pc = 32'h0000_5000;
    pulse_req(1);
    wait_beats(1, 1, 20);
    if (q1.size() >= 1) begin
      check_eq("t5_wrap_tag", {24'h0, q1[0].tag}, 32'h0);
      check_eq("t5_wrap_data", q1[0].data, 32'h0);
    end
    wait_beats(1, 42, 200);
    step(3);

    // 6: small instance, 4 registers and 1 memory word
    pc = 32'h0000_6000;
    pulse_req(2);
    wait_beats(2, 7, 50);
    check_dump(2, 0, 4, 1, 32'd1, 32'h0000_6000, "t6");
    step(5);
    check_eq("t6_count", 32'(q2.size()), 32'd7);
    check_eq("t6_mem_addr", {24'h0, mem_addr2}, 32'h0);
    check_eq("t6_busy", {31'h0, busy2}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
